cop0_regfile: RTL and testbench
===============================

COP0_REGFILE -- requirements
Module: cop0_regfile

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: we  in  1  commit-stage CP0 write enable (MTC0 / write_cop0).
REQ-004 SHALL have: waddr  in  5  write register number; wsel  in  3  write select.
REQ-005 SHALL have: wdata  in  32  write data.
REQ-006 SHALL have: raddr  in  5  read register number; rsel  in  3  read select; rdata  out  32  read data (MFC0).
REQ-007 SHALL have: eret  in  1  committed ERET.
REQ-008 SHALL have: exc_valid  in  1  committed exception; exc_code  in  5  ExcCode; exc_pc  in  32  faulting PC; exc_bd  in  1  in delay slot.
REQ-009 SHALL have: exc_bad_valid  in  1  BadVAddr update; exc_badvaddr  in  32  faulting address.
REQ-010 SHALL have: hw_int  in  6  hardware interrupt lines, level-sensitive.
REQ-011 SHALL have: status, cause, epc  out  32 each  current register values; int_pending  out  1  interrupt request.

Function
REQ-012 SHALL implement: BadVAddr(8,0) RO, Count(9,0), Compare(11,0), Status(12,0), Cause(13,0), EPC(14,0), PRId(15,0) RO constant 0x0001_8000; all other (reg,sel) read 0 and ignore writes.
REQ-013 Status writable bits SHALL be IM[15:8], EXL[1], IE[0]; BEV[22] reads 1; all others read 0.
REQ-014 Cause SHALL hold BD[31], TI[30], IP[15:8], ExcCode[6:2]; only IP[9:8] software-writable; others 0.
REQ-015 Cause.IP[15:10] SHALL register hw_int each cycle (1-cycle latency), with IP[15] = hw_int[5] | TI.
REQ-016 Count SHALL increment by 1 every second cycle via an internal prescale toggle, wrapping 0xFFFF_FFFF -> 0.
REQ-017 Writing Count SHALL load wdata and clear the toggle; next increment occurs 2 cycles after the write.
REQ-018 TI SHALL set in the cycle after Count equals Compare (non-zero-length match); a Compare write SHALL clear TI, having priority over a same-cycle match.
REQ-019 rdata SHALL be combinational; a same-cycle we to the read address SHALL forward wdata (masked per REQ-013/014).
REQ-020 On exc_valid with EXL=0: EPC <= exc_bd ? exc_pc-4 : exc_pc; BD <= exc_bd; EXL <= 1; ExcCode <= exc_code.
REQ-021 On exc_valid with EXL=1: EPC and BD SHALL be unchanged; ExcCode updated; EXL stays 1.
REQ-022 BadVAddr SHALL load exc_badvaddr only when exc_valid & exc_bad_valid.
REQ-023 eret SHALL clear EXL next cycle.
REQ-024 Same-cycle priority: exc_valid > eret > we; lower-priority Status/Cause/EPC updates SHALL be dropped; a dropped we SHALL still not alter Count/Compare.
REQ-025 int_pending = IE & ~EXL & |(Cause.IP & Status.IM), combinational from registered state.
REQ-026 Arithmetic SHALL be 32-bit unsigned, wrap-around, no overflow flag.

Reset
REQ-027 On reset_n low (async), Status=0x0040_0000, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, toggle=0, TI=0; int_pending=0; rdata reflects reset state.
REQ-028 Deassertion SHALL be synchronous to clk; first Count increment 2 cycles after deassertion.
REQ-029 Reset mid-exception or mid-eret SHALL discard the event.

Verification
REQ-030 MTC0 Status 0xFFFF_FFFF -> MFC0 Status reads 0x0040_FF03; Cause IP write 0x0000_0300 then IE=1, IM=0x03, EXL=0 -> int_pending=1.
REQ-031 Compare=10, Count=0 -> TI and int_pending (IM7, IE set) after 20-21 cycles; Compare write -> TI=0 next cycle.
REQ-032 exc_valid, exc_pc=0x8000_0104, exc_bd=1, code=12 -> EPC=0x8000_0100, BD=1, EXL=1, ExcCode=12; second exc with EXL=1 -> EPC unchanged.
REQ-033 eret with EXL=1 -> EXL=0; simultaneous exc_valid+eret+we(Status) -> EXL=1, Status write dropped.
REQ-034 Count=0xFFFF_FFFF -> 0 after 2 cycles; read of reg 5 sel 0 -> 0; PRId -> 0x0001_8000.
REQ-035 Assert reset_n low mid-run -> all registers reach reset values without clock edge.

Source files
------------

// File: rtl/cop0_regfile.sv
// MIPS CP0 register file: Status, Cause, EPC, BadVAddr, Count/Compare timer and PRId.
// Commit-stage exceptions, ERET and MTC0 writes are applied with exception > eret > write priority.
module cop0_regfile (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [2:0]  wsel,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    input  logic [2:0]  rsel,
    output logic [31:0] rdata,
    input  logic        eret,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic        exc_bad_valid,
    input  logic [31:0] exc_badvaddr,
    input  logic [5:0]  hw_int,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic [31:0] epc,
    output logic        int_pending
);

    localparam logic [4:0]  RegBadVAddr = 5'd8;
    localparam logic [4:0]  RegCount    = 5'd9;
    localparam logic [4:0]  RegCompare  = 5'd11;
    localparam logic [4:0]  RegStatus   = 5'd12;
    localparam logic [4:0]  RegCause    = 5'd13;
    localparam logic [4:0]  RegEpc      = 5'd14;
    localparam logic [4:0]  RegPrid     = 5'd15;
    localparam logic [31:0] PridValue   = 32'h0001_8000;

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic        ti_q, ti_d;
    logic [5:0]  hw_q, hw_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        toggle_q, toggle_d;

    logic        wr_en;
    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic [7:0]  ip;

    function automatic logic [31:0] pack_status(input logic [7:0] im, input logic exl,
                                                input logic ie);
        return {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
    endfunction

    function automatic logic [31:0] pack_cause(input logic bd, input logic ti,
                                               input logic [7:0] ipv, input logic [4:0] code);
        return {bd, ti, 14'b0, ipv, 1'b0, code, 2'b0};
    endfunction

    // A write that loses to a same-cycle exception or eret is dropped entirely.
    assign wr_en      = we & ~exc_valid & ~eret & (wsel == 3'd0);
    assign wr_count   = wr_en & (waddr == RegCount);
    assign wr_compare = wr_en & (waddr == RegCompare);
    assign wr_status  = wr_en & (waddr == RegStatus);
    assign wr_cause   = wr_en & (waddr == RegCause);
    assign wr_epc     = wr_en & (waddr == RegEpc);

    assign ip          = {hw_q[5] | ti_q, hw_q[4:0], ip_sw_q};
    assign status      = pack_status(im_q, exl_q, ie_q);
    assign cause       = pack_cause(bd_q, ti_q, ip, exccode_q);
    assign epc         = epc_q;
    assign int_pending = ie_q & ~exl_q & |(ip & im_q);

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        hw_d       = hw_int;
        ip_sw_d    = ip_sw_q;
        exccode_d  = exccode_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        compare_d  = compare_q;
        toggle_d   = ~toggle_q;
        count_d    = toggle_q ? count_q + 32'd1 : count_q;

        if (wr_count) begin
            count_d  = wdata;
            toggle_d = 1'b0;
        end
        if (wr_compare) begin
            compare_d = wdata;
        end
        if (wr_compare) begin
            ti_d = 1'b0;
        end else if (count_q == compare_q) begin
            ti_d = 1'b1;
        end

        if (exc_valid) begin
            exccode_d = exc_code;
            exl_d     = 1'b1;
            // Nested exceptions keep the original return point.
            if (!exl_q) begin
                epc_d = exc_bd ? exc_pc - 32'd4 : exc_pc;
                bd_d  = exc_bd;
            end
            if (exc_bad_valid) begin
                badvaddr_d = exc_badvaddr;
            end
        end else if (eret) begin
            exl_d = 1'b0;
        end else begin
            if (wr_status) begin
                im_d  = wdata[15:8];
                exl_d = wdata[1];
                ie_d  = wdata[0];
            end
            if (wr_cause) begin
                ip_sw_d = wdata[9:8];
            end
            if (wr_epc) begin
                epc_d = wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            hw_q       <= '0;
            ip_sw_q    <= '0;
            exccode_q  <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            toggle_q   <= 1'b0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            hw_q       <= hw_d;
            ip_sw_q    <= ip_sw_d;
            exccode_q  <= exccode_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            toggle_q   <= toggle_d;
        end
    end

    // Combinational MFC0; a same-cycle MTC0 to the same register is forwarded with masking.
    always_comb begin
        logic fwd;
        fwd   = wr_en & (waddr == raddr);
        rdata = '0;
        if (rsel == 3'd0) begin
            case (raddr)
                RegBadVAddr: rdata = badvaddr_q;
                RegCount:    rdata = fwd ? wdata : count_q;
                RegCompare:  rdata = fwd ? wdata : compare_q;
                RegStatus:   rdata = fwd ? pack_status(wdata[15:8], wdata[1], wdata[0]) : status;
                RegCause:    rdata = fwd ? pack_cause(bd_q, ti_q, {ip[7:2], wdata[9:8]}, exccode_q)
                                         : cause;
                RegEpc:      rdata = fwd ? wdata : epc_q;
                RegPrid:     rdata = PridValue;
                default:     rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cop0_regfile.sv
// Scoreboard bench for cop0_regfile: expectations are queued as stimulus is applied and
// compared against the selected DUT output when the result is due.
module tb_cop0_regfile;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        we;
    logic [4:0]  waddr;
    logic [2:0]  wsel;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [2:0]  rsel;
    logic [31:0] rdata;
    logic        eret;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        exc_bad_valid;
    logic [31:0] exc_badvaddr;
    logic [5:0]  hw_int;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        int_pending;

    cop0_regfile dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .we           (we),
        .waddr        (waddr),
        .wsel         (wsel),
        .wdata        (wdata),
        .raddr        (raddr),
        .rsel         (rsel),
        .rdata        (rdata),
        .eret         (eret),
        .exc_valid    (exc_valid),
        .exc_code     (exc_code),
        .exc_pc       (exc_pc),
        .exc_bd       (exc_bd),
        .exc_bad_valid(exc_bad_valid),
        .exc_badvaddr (exc_badvaddr),
        .hw_int       (hw_int),
        .status       (status),
        .cause        (cause),
        .epc          (epc),
        .int_pending  (int_pending)
    );

    always #5 clk = ~clk;

    typedef enum int {SrcRdata, SrcStatus, SrcCause, SrcEpc, SrcIntPending} src_e;
    typedef struct {
        string       tag;
        src_e        src;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input src_e src, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.src = src;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.src)
                SrcRdata:  obs = rdata;
                SrcStatus: obs = status;
                SrcCause:  obs = cause;
                SrcEpc:    obs = epc;
                default:   obs = {31'b0, int_pending};
            endcase
            check_val(e.tag, obs, e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        waddr = a;
        wsel  = 3'd0;
        wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic mfc0(input string tag, input logic [4:0] a, input logic [2:0] s,
                        input logic [31:0] exp);
        raddr = a;
        rsel  = s;
        #1;
        push(tag, SrcRdata, exp);
        drain();
    endtask

    initial begin
        reset_n = 1'b0; we = 1'b0; waddr = '0; wsel = '0; wdata = '0;
        raddr = 5'd12; rsel = '0; eret = 1'b0; exc_valid = 1'b0; exc_code = '0;
        exc_pc = '0; exc_bd = 1'b0; exc_bad_valid = 1'b0; exc_badvaddr = '0; hw_int = '0;
        #2;
        push("rst_status", SrcStatus, 32'h0040_0000);
        push("rst_cause", SrcCause, 32'h0);
        push("rst_epc", SrcEpc, 32'h0);
        push("rst_intp", SrcIntPending, 32'h0);
        push("rst_rdata", SrcRdata, 32'h0040_0000);
        drain();

        step();
        reset_n = 1'b1;
        mfc0("count_t0", 5'd9, 3'd0, 32'd0);
        step();
        mfc0("count_t1", 5'd9, 3'd0, 32'd0);
        step();
        mfc0("count_t2", 5'd9, 3'd0, 32'd1);
        mfc0("prid", 5'd15, 3'd0, 32'h0001_8000);
        mfc0("reg5", 5'd5, 3'd0, 32'h0);
        mfc0("prid_sel1", 5'd15, 3'd1, 32'h0);

        mtc0(5'd11, 32'hFFFF_0000);
        push("cause_ti_clr", SrcCause, 32'h0);
        drain();

        // Status write-mask with forwarding on the write cycle.
        we = 1'b1; waddr = 5'd12; wsel = 3'd0; wdata = 32'hFFFF_FFFF;
        mfc0("status_fwd", 5'd12, 3'd0, 32'h0040_FF03);
        step();
        we = 1'b0;
        push("status_mask", SrcStatus, 32'h0040_FF03);
        push("intp_exl", SrcIntPending, 32'h0);
        drain();

        mtc0(5'd12, 32'h0000_0301);
        push("status_ie", SrcStatus, 32'h0040_0301);
        push("intp_none", SrcIntPending, 32'h0);
        drain();
        we = 1'b1; waddr = 5'd13; wsel = 3'd0; wdata = 32'hFFFF_FFFF;
        mfc0("cause_fwd", 5'd13, 3'd0, 32'h0000_0300);
        step();
        we = 1'b0;
        push("cause_sw_ip", SrcCause, 32'h0000_0300);
        push("intp_sw", SrcIntPending, 32'h1);
        drain();

        hw_int = 6'b000100;
        #1;
        push("hw_lat0", SrcCause, 32'h0000_0300);
        drain();
        step();
        hw_int = 6'b0;
        push("hw_lat1", SrcCause, 32'h0000_1300);
        drain();
        step();
        push("hw_clr", SrcCause, 32'h0000_0300);
        drain();
        mtc0(5'd13, 32'h0);
        push("intp_off", SrcIntPending, 32'h0);
        drain();

        // Timer: Count=0 then Compare=10; TI appears 20 cycles after the Compare write.
        mtc0(5'd12, 32'h0000_8001);
        push("status_im7", SrcStatus, 32'h0040_8001);
        drain();
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd10);
        for (int i = 0; i < 19; i++) step();
        push("ti_early", SrcCause, 32'h0);
        drain();
        step();
        push("ti_set", SrcCause, 32'h4000_8000);
        push("intp_timer", SrcIntPending, 32'h1);
        drain();
        mtc0(5'd11, 32'hFFFF_0000);
        push("ti_cmp_clr", SrcCause, 32'h0);
        push("intp_t_off", SrcIntPending, 32'h0);
        drain();

        exc_valid = 1'b1; exc_pc = 32'h8000_0104; exc_bd = 1'b1; exc_code = 5'd12;
        exc_bad_valid = 1'b1; exc_badvaddr = 32'hDEAD_BEEF;
        step();
        exc_valid = 1'b0; exc_bad_valid = 1'b0;
        push("exc_epc", SrcEpc, 32'h8000_0100);
        push("exc_cause", SrcCause, 32'h8000_0030);
        push("exc_status", SrcStatus, 32'h0040_8003);
        push("exc_intp", SrcIntPending, 32'h0);
        drain();
        mfc0("badvaddr", 5'd8, 3'd0, 32'hDEAD_BEEF);

        exc_valid = 1'b1; exc_pc = 32'h8000_0200; exc_bd = 1'b0; exc_code = 5'd4;
        exc_badvaddr = 32'h1234_5678;
        step();
        exc_valid = 1'b0;
        push("exc2_epc", SrcEpc, 32'h8000_0100);
        push("exc2_cause", SrcCause, 32'h8000_0010);
        drain();
        mfc0("badv_keep", 5'd8, 3'd0, 32'hDEAD_BEEF);

        eret = 1'b1;
        step();
        eret = 1'b0;
        push("eret_status", SrcStatus, 32'h0040_8001);
        drain();

        exc_valid = 1'b1; exc_pc = 32'h8000_1000; exc_bd = 1'b0; exc_code = 5'd8;
        eret = 1'b1; we = 1'b1; waddr = 5'd12; wsel = 3'd0; wdata = 32'h0;
        step();
        exc_valid = 1'b0; eret = 1'b0; we = 1'b0;
        push("prio_status", SrcStatus, 32'h0040_8003);
        push("prio_epc", SrcEpc, 32'h8000_1000);
        push("prio_cause", SrcCause, 32'h0000_0020);
        drain();
        eret = 1'b1;
        step();
        eret = 1'b0;

        mtc0(5'd9, 32'hFFFF_FFFF);
        mfc0("wrap_t0", 5'd9, 3'd0, 32'hFFFF_FFFF);
        step();
        mfc0("wrap_t1", 5'd9, 3'd0, 32'hFFFF_FFFF);
        step();
        mfc0("wrap_t2", 5'd9, 3'd0, 32'h0);

        // Asynchronous reset between clock edges.
        #2;
        reset_n = 1'b0;
        #1;
        push("arst_status", SrcStatus, 32'h0040_0000);
        push("arst_epc", SrcEpc, 32'h0);
        push("arst_cause", SrcCause, 32'h0);
        push("arst_intp", SrcIntPending, 32'h0);
        drain();
        mfc0("arst_count", 5'd9, 3'd0, 32'h0);
        mfc0("arst_badv", 5'd8, 3'd0, 32'h0);

        exc_valid = 1'b1; exc_pc = 32'h8000_2000; exc_code = 5'd3; eret = 1'b1;
        step();
        exc_valid = 1'b0; eret = 1'b0;
        push("rst_exc_status", SrcStatus, 32'h0040_0000);
        push("rst_exc_epc", SrcEpc, 32'h0);
        drain();
        reset_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
